// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller for an LSB-first 8N1 frame.
// It synchronises the serial line, detects the start bit and enables an external
// RX baud generator. The generator returns a mid-bit tick, and each bit is sampled
// on that tick.
// At the end of a frame the controller presents the received byte with a one-cycle
// strobe and a framing-error flag.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between
// the data and stop bits, together with a registered perr output.
module uart_rx_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 baud_tick,
    output logic                 baud_ena,
    output logic [DATA_BITS-1:0] data,
    output logic                 rcv,
    output logic                 ferr,
`ifdef UART_RX_PARITY_EN
    output logic                 perr,
`endif
    output logic                 busy
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd5,
`endif
        ST_LOAD   = 3'd4
    } state_t;

    logic [1:0]           sync_q;
    logic                 rx_s;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_ok_q, stop_ok_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ferr_q, ferr_d;
    logic                 rcv_q, rcv_d;
    logic                 baud_ena_q, baud_ena_d;
    logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 perr_q, perr_d;
`endif

    // Two-flop synchroniser; it resets to the idle-high line level so that reset
    // cannot produce a false start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    // Next-state logic. baud_ena and busy are decoded from the next state, so once
    // registered they follow the state register without glitches.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        stop_ok_d = stop_ok_q;
        data_d    = data_q;
        ferr_d    = ferr_q;
        rcv_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = perr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (baud_tick) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    // Right shift, so the first bit received ends up at bit 0.
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                // Even parity: data bits XOR parity bit must be 0.
                if (baud_tick) begin
                    par_bad_d = (^shift_q) ^ rx_s;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    stop_ok_d = rx_s;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // The byte is published even on a framing error.
                data_d  = shift_q;
                ferr_d  = ~stop_ok_q;
                rcv_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
                perr_d  = par_bad_q;
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        baud_ena_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
`ifdef UART_RX_PARITY_EN
        if (state_d == ST_PARITY) begin
            baud_ena_d = 1'b1;
        end
`endif
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            stop_ok_q  <= 1'b0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
            rcv_q      <= 1'b0;
            baud_ena_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            stop_ok_q  <= stop_ok_d;
            data_q     <= data_d;
            ferr_q     <= ferr_d;
            rcv_q      <= rcv_d;
            baud_ena_q <= baud_ena_d;
            busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign baud_ena = baud_ena_q;
    assign data     = data_q;
    assign rcv      = rcv_q;
    assign ferr     = ferr_q;
    assign busy     = busy_q;
`ifdef UART_RX_PARITY_EN
    assign perr     = perr_q;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller that sequences the RX baud generator. It detects the start bit, enables the baud generator through its clock-enable input, and samples each bit on the mid-bit tick the generator returns. It shifts in an LSB-first 8N1 frame, then presents the byte with a one-cycle strobe and a framing-error flag. It sits between the pad-level `rx` line and the byte consumer (command decoder / FIFO).

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8), LSB first.

Ports:
clk  input  1  system clock (100 MHz).
rst  input  1  reset, synchronous, active-high.
rx  input  1  asynchronous serial line, idle high.
baud_tick  input  1  one-clk-wide mid-bit pulse from the RX baud generator output.
baud_ena  output  1  enable to the RX baud generator clock-enable input; 0 holds it frozen/initialised.
data  output  DATA_BITS  last received byte, LSB = first bit on the line.
rcv  output  1  one-clk strobe: `data`/`ferr` updated this cycle.
ferr  output  1  framing error of the last frame (stop bit sampled 0).
busy  output  1  frame reception in progress (state != IDLE).

Behaviour:
- Single clock domain; reset is synchronous and active-high. All state changes occur on the rising edge of `clk`.
- Reset values:
  - `baud_ena`=0, `data`=0, `rcv`=0, `ferr`=0, `busy`=0, state=IDLE.
  - Synchroniser flops=1; bit counter=0; shift register=0.
- `rx` passes through a 2-flop synchroniser (`rx_s`). All decisions use `rx_s` only.
- FSM states: IDLE, START, DATA, STOP, LOAD (plus PARITY, see Optional Feature).
  - IDLE: `baud_ena`=0. If `rx_s`==0, go to START next edge.
  - START: `baud_ena`=1. The generator restarts from its frozen value, so the first `baud_tick` falls mid start bit.
    - On tick with `rx_s`==1: false start (glitch). Return to IDLE; no `rcv`, outputs unchanged.
    - On tick with `rx_s`==0: go to DATA, clear bit counter.
  - DATA: `baud_ena`=1. On each tick, shift `rx_s` in at the MSB end (right shift), so the first bit ends at bit 0 after DATA_BITS ticks.
    - Bit counter increments per tick.
    - After tick number DATA_BITS, go to STOP. The counter wraps to 0 and never exceeds DATA_BITS-1 in DATA.
  - STOP: `baud_ena`=1. On tick, capture stop_ok=`rx_s` and go to LOAD.
  - LOAD: `baud_ena`=0.
    - Next edge: `data`<=shift register, `ferr`<=~stop_ok, `rcv`=1 for exactly one cycle, then IDLE.
    - `data` is updated even when `ferr`=1 (break frame gives `data`=0, `ferr`=1).
- `baud_ena` and `busy` are decoded from the registered state, so they are glitch-free.
  - `busy`=1 in START, DATA, PARITY, STOP, LOAD.
- Ticks arriving while `baud_ena`=0 are ignored. Non-tick cycles hold state.
- Latency: `rcv` asserts 1 clk after the stop-bit tick (LOAD). Falling edge on `rx` to START is 3 clk (2 sync + 1 state).
- Back-to-back frames: IDLE is re-entered ~half a bit before the next start edge, so contiguous frames are received without loss.
- `data`/`ferr` hold their value until the next `rcv`.
- A frame still at `rx`==0 after STOP (break) is re-detected in IDLE as a new start; this is acceptable.
- Reset mid-frame: next edge returns to IDLE with `baud_ena`=0. No `rcv` is produced; partial data is discarded; `data`/`ferr` reset to 0.

Optional Feature:
Macro `UART_RX_PARITY_EN`.
- Defined:
  - PARITY state inserted between DATA and STOP; on tick it samples the parity bit.
  - Even parity: XOR of data bits and parity bit must be 0.
  - Extra output port `perr` (1 bit, reset 0) is registered in LOAD alongside `ferr`.
- Undefined: no PARITY state and no `perr` port; the frame is 8N1.

Test Plan:
- Bench uses the real baud generator with M=16. Frame 0x55, stop=1 -> single `rcv` pulse 1 clk after the stop tick; `data`=0x55, `ferr`=0; `busy` low after LOAD.
- 3-clk low glitch on `rx` while idle -> START entered, tick sees `rx_s`=1, back to IDLE; no `rcv`, `data` unchanged, `baud_ena`=0 afterwards.
- Frame 0xA3 with stop bit 0 -> `rcv`=1, `data`=0xA3, `ferr`=1. Following good frame 0x0F -> `ferr` returns to 0.
- Back-to-back 0x01 then 0xFF, no idle gap -> two `rcv` pulses ~10 bit periods apart; `data` 0x01 then 0xFF.
- Assert `rst` for 1 clk during data bit 3 of 0x3C -> `baud_ena`=0 and `busy`=0 next edge; no `rcv`. Next frame 0x3C is received correctly.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 -> `perr`=0. The same frame with parity bit 0 -> `perr`=1, `data`=0x07.
